// File: rtl/regfile_dump_reader.sv
// Sequential reader for a spare register-file read port: walks FIRST_REG..LAST_REG
// and streams each live register value out over a valid/ready interface.
module regfile_dump_reader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    // ptr carries one extra bit so it can sit at LAST_REG+1 without wrapping.
    localparam logic [ADDR_W:0]   PTR_FIRST = (ADDR_W + 1)'(FIRST_REG);
    localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(LAST_REG);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = PTR_FIRST;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    ptr_d       = PTR_FIRST;
                    state_d     = IDLE;
                end else begin
                    out_data_d  = rd_data;
                    out_index_d = ptr_q[ADDR_W-1:0];
                    out_valid_d = 1'b1;
                    ptr_d       = ptr_q + PTR_ONE;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                // abort wins over a coincident handshake; that word is dropped.
                if (abort) begin
                    out_valid_d = 1'b0;
                    ptr_d       = PTR_FIRST;
                    state_d     = IDLE;
                end else if (out_valid_q && out_ready) begin
                    if (out_index_q == IDX_LAST) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        ptr_d       = PTR_FIRST;
                        state_d     = IDLE;
                    end else begin
                        out_data_d  = rd_data;
                        out_index_d = ptr_q[ADDR_W-1:0];
                        ptr_d       = ptr_q + PTR_ONE;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                ptr_d       = PTR_FIRST;
                state_d     = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_FIRST;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr   = ptr_q[ADDR_W-1:0];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_valid_q && (out_index_q == IDX_LAST);
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
